dmem_responder: RTL

Responder side of the data-memory access interface driven by the pipelined CPU's MEM stage. Accepts one load or store request at a time through a valid/ready handshake, holds it for a programmable wait latency, and returns a response through a second valid/ready handshake. Owns a word-addressed storage array. `busy` lets the pipeline stall MEM while a request is in flight.

---
 rtl/dmem_pkg.sv | 7 +
 rtl/dmem_wait_counter.sv | 18 +
 rtl/dmem_responder.sv | 83 ++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and sizing constants for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int LAT_MAX = 15;
  localparam int CNT_W = 4;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/dmem_wait_counter.sv
// dmem_wait_counter: loadable down-counter that flags the last wait cycle
module dmem_wait_counter
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  // load on accept, otherwise count down and park at zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = load ? (value == '0) : (cnt == CNT_W'(1));
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with programmable wait latency
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  state_t state;
  logic wr_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [DEPTH];
  logic accept, done, enter_resp, consume, acc_wr, acc_err;
  logic [31:0] acc_addr, acc_wdata;
  logic [AW-1:0] idx;
  assign req_ready  = state == IDLE;
  assign busy       = state != IDLE;
  assign resp_valid = state == RESP;
  assign accept     = req_ready && req_valid;
  assign consume    = resp_valid && resp_ready;
  assign enter_resp = (accept || state == WAIT) && done;
  assign acc_wr     = req_ready ? req_write : wr_q;
  assign acc_addr   = req_ready ? req_addr : addr_q;
  assign acc_wdata  = req_ready ? req_wdata : wdata_q;
  assign acc_err    = (acc_addr[1:0] != 2'b00) || (acc_addr >= 32'(DEPTH * WORD_BYTES));
  assign idx        = acc_addr[AW+1:2];
  dmem_wait_counter u_cnt (
    .clk  (clk),
    .reset(reset),
    .load (accept),
    .value(CNT_W'(LATENCY)),
    .done (done)
  );
  // state sequencing: IDLE -> WAIT -> RESP -> IDLE, skipping WAIT at zero latency
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else if (enter_resp) state <= RESP;
    else if (accept) state <= WAIT;
    else if (consume) state <= IDLE;
  // request capture held through the wait period
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  // response registers loaded on the RESP-entry edge, cleared when consumed
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_rdata <= (!acc_wr && !acc_err) ? mem[idx] : '0;
      resp_err   <= acc_err;
    end else if (consume) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end
  // storage array: cleared by reset, written by an error-free store entering RESP
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enter_resp && acc_wr && !acc_err) begin
      mem[idx] <= acc_wdata;
    end
endmodule
